// File: rtl/ram_port_arbiter_pkg.sv
// Shared width helpers and request-entry layout for the multi-port frame RAM front end.
// An entry is packed as {wr, addr, wdata} with wdata in the low bits.
package ram_port_arbiter_pkg;

    localparam int DEFAULT_ADDRESS_WIDTH   = 14;
    localparam int DEFAULT_DATA_WIDTH      = 8;
    localparam int DEFAULT_PORTS           = 3;
    localparam int DEFAULT_FIFO_DEPTH      = 8;
    localparam int DEFAULT_MAX_BURST       = 4;
    localparam int DEFAULT_RAM_LATENCY     = 2;

    function automatic int ptrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int countWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int burstWidth(input int maxBurst);
        return $clog2(maxBurst + 1);
    endfunction

    function automatic int portIdxWidth(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

    function automatic int entryWidth(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

    function automatic int entryAddrLsb(input int dw);
        return dw;
    endfunction

    function automatic int entryWrBit(input int aw, input int dw);
        return aw + dw;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM-side signal bundle of the frame RAM arbiter.
// The slave modport is the arbiter; the master side drives requests and the RAM read data.
interface ram_port_arbiter_if #(
    parameter int ADDRESS_WIDTH = 14,
    parameter int DATA_WIDTH    = 8,
    parameter int PORTS         = 3
);
    logic [PORTS-1:0]               req_valid;
    logic [PORTS-1:0]               req_ready;
    logic [PORTS-1:0]               req_wr;
    logic [PORTS*ADDRESS_WIDTH-1:0] req_addr;
    logic [PORTS*DATA_WIDTH-1:0]    req_wdata;
    logic [PORTS-1:0]               rsp_valid;
    logic [DATA_WIDTH-1:0]          rsp_data;
    logic [ADDRESS_WIDTH-1:0]       ram_address;
    logic                           ram_wren;
    logic [DATA_WIDTH-1:0]          ram_data;
    logic [DATA_WIDTH-1:0]          ram_q;

    modport master (
        output req_valid, req_wr, req_addr, req_wdata, ram_q,
        input  req_ready, rsp_valid, rsp_data, ram_address, ram_wren, ram_data
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_wdata, ram_q,
        output req_ready, rsp_valid, rsp_data, ram_address, ram_wren, ram_data
    );
endinterface

// File: rtl/ram_port_fifo.sv
// Single-clock request FIFO for one arbiter port; head entry is visible combinationally.
// DEPTH must be a power of two so the pointers wrap naturally.
module ram_port_fifo
    import ram_port_arbiter_pkg::*;
#(
    parameter int WIDTH = 23,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic [WIDTH-1:0]             i_data,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [countWidth(DEPTH)-1:0] o_count
);
    localparam int PW = ptrWidth(DEPTH);
    localparam int CW = countWidth(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wrPtr;
    logic [PW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rdPtr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // Storage needs no reset: nothing is read until the count says it was written.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wrPtr] <= i_data;
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// Weighted round-robin front end to the single-port frame RAM: per-port FIFOs, burst-limited
// arbiter, registered RAM command outputs and a one-hot tag pipe that routes read data back.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH   = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int PORTS           = DEFAULT_PORTS,
    parameter int PORT_FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int MAX_BURST       = DEFAULT_MAX_BURST,
    parameter int RAM_LATENCY     = DEFAULT_RAM_LATENCY
) (
    input logic               clk,
    input logic               reset_n,
    ram_port_arbiter_if.slave io_bus
);
    localparam int AW       = ADDRESS_WIDTH;
    localparam int DW       = DATA_WIDTH;
    localparam int EW       = entryWidth(AW, DW);
    localparam int CW       = countWidth(PORT_FIFO_DEPTH);
    localparam int BW       = burstWidth(MAX_BURST);
    localparam int IW       = portIdxWidth(PORTS);
    localparam int ADDR_LSB = entryAddrLsb(DW);
    localparam int WR_BIT   = entryWrBit(AW, DW);

    logic [EW-1:0]    w_pushEntry [PORTS];
    logic [EW-1:0]    w_head [PORTS];
    logic [CW-1:0]    w_count [PORTS];
    logic [PORTS-1:0] w_push;
    logic [PORTS-1:0] w_pop;
    logic [PORTS-1:0] w_full;
    logic [PORTS-1:0] w_empty;
    logic [PORTS-1:0] w_ready;

    logic             w_grantValid;
    logic [IW-1:0]    w_grantIdx;
    logic [IW-1:0]    w_candIdx;
    logic             w_otherBusy;
    logic [EW-1:0]    w_grantEntry;

    logic [IW-1:0]    r_cur;
    logic [BW-1:0]    r_burst;
    logic [AW-1:0]    r_ramAddress;
    logic             r_ramWren;
    logic [DW-1:0]    r_ramData;
    logic [PORTS-1:0] r_tag [RAM_LATENCY+1];

    genvar k;
    generate
        for (k = 0; k < PORTS; k++) begin : g_port
            // Ready comes from the registered count, so a same-cycle pop never frees a slot.
            assign w_ready[k]     = (w_count[k] != CW'(PORT_FIFO_DEPTH));
            assign w_push[k]      = io_bus.req_valid[k] && !w_full[k];
            assign w_pop[k]       = w_grantValid && (w_grantIdx == IW'(k));
            assign w_pushEntry[k] = {io_bus.req_wr[k], io_bus.req_addr[k*AW +: AW],
                                     io_bus.req_wdata[k*DW +: DW]};

            ram_port_fifo #(.WIDTH(EW), .DEPTH(PORT_FIFO_DEPTH)) u_fifo (
                .clk     (clk),
                .reset_n (reset_n),
                .i_push  (w_push[k]),
                .i_pop   (w_pop[k]),
                .i_data  (w_pushEntry[k]),
                .o_data  (w_head[k]),
                .o_full  (w_full[k]),
                .o_empty (w_empty[k]),
                .o_count (w_count[k])
            );
        end
    endgenerate

    // Stay on cur until its burst is spent (unless nobody else waits), then rotate.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantIdx   = r_cur;
        w_candIdx    = r_cur;
        w_otherBusy  = |(~w_empty & ~(PORTS'(1) << r_cur));
        if (!w_empty[r_cur] && ((r_burst < BW'(MAX_BURST)) || !w_otherBusy)) begin
            w_grantValid = 1'b1;
        end else begin
            for (int i = 1; i < PORTS; i++) begin
                w_candIdx = IW'((int'(r_cur) + i) % PORTS);
                if (!w_grantValid && !w_empty[w_candIdx]) begin
                    w_grantValid = 1'b1;
                    w_grantIdx   = w_candIdx;
                end
            end
        end
    end

    assign w_grantEntry = w_head[w_grantIdx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ramAddress <= '0;
            r_ramWren    <= 1'b0;
            r_ramData    <= '0;
            r_cur        <= '0;
            r_burst      <= '0;
        end else begin
            r_ramWren <= 1'b0;
            if (w_grantValid) begin
                r_ramAddress <= w_grantEntry[ADDR_LSB +: AW];
                r_ramData    <= w_grantEntry[0 +: DW];
                r_ramWren    <= w_grantEntry[WR_BIT];
                if (w_grantIdx == r_cur) begin
                    if (r_burst != BW'(MAX_BURST)) r_burst <= r_burst + 1'b1;
                end else begin
                    r_cur   <= w_grantIdx;
                    r_burst <= BW'(1);
                end
            end
        end
    end

    // Stage 0 lines up with the RAM command registers; the last stage lines up with ram_q.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s <= RAM_LATENCY; s++) r_tag[s] <= '0;
        end else begin
            r_tag[0] <= (w_grantValid && !w_grantEntry[WR_BIT]) ? w_pop : '0;
            for (int s = 1; s <= RAM_LATENCY; s++) r_tag[s] <= r_tag[s-1];
        end
    end

    assign io_bus.req_ready   = w_ready;
    assign io_bus.rsp_valid   = r_tag[RAM_LATENCY];
    assign io_bus.rsp_data    = io_bus.ram_q;
    assign io_bus.ram_address = r_ramAddress;
    assign io_bus.ram_wren    = r_ramWren;
    assign io_bus.ram_data    = r_ramData;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: behavioural RAM, per-port expected-read queues filled at
// acceptance and drained by a response monitor, plus directed timing/arbitration checks.
module tb_ram_port_arbiter;
    localparam int AW = 14;
    localparam int DW = 8;
    localparam int P  = 3;
    localparam int L  = 2;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .PORTS(P)) bus ();

    ram_port_arbiter #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .PORTS(P),
        .PORT_FIFO_DEPTH(8), .MAX_BURST(4), .RAM_LATENCY(L)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io_bus  (bus.slave)
    );

    int nCompared   = 0;
    int nMismatched = 0;
    int cycle       = 0;
    int acc [P];
    logic [7:0] expQ [P][$];
    int rspPort [$];
    int rspCycle [$];
    logic [7:0] goldMem [0:(1<<AW)-1];
    logic [7:0] ramMem [0:(1<<AW)-1];
    logic [7:0] qPipe [L];
    logic memLoaded = 1'b0;

    function automatic logic [7:0] initByte(input logic [AW-1:0] a);
        if (a == 14'h0010) return 8'hA5;
        return a[7:0] ^ {a[13:8], 2'b01};
    endfunction

    // Behavioural RAM: L registers from address sample to q.
    always @(posedge clk) begin
        if (!memLoaded) begin
            for (int a = 0; a < (1 << AW); a++) ramMem[a] <= initByte(AW'(a));
            memLoaded <= 1'b1;
        end else if (bus.ram_wren) begin
            ramMem[bus.ram_address] <= bus.ram_data;
        end
        qPipe[0] <= ramMem[bus.ram_address];
        for (int i = 1; i < L; i++) qPipe[i] <= qPipe[i-1];
    end
    assign bus.ram_q = qPipe[L-1];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        assert (observed === expected) else begin
            nMismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Response monitor: every strobe must be one-hot and match the oldest expected read of its port.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && bus.rsp_valid !== '0) begin
            checkOutput("rsp_onehot", 32'($onehot(bus.rsp_valid)), 32'd1);
            for (int k = 0; k < P; k++) begin
                if (bus.rsp_valid[k]) begin
                    rspPort.push_back(k);
                    rspCycle.push_back(cycle);
                    checkOutput($sformatf("rsp_expected_p%0d", k), 32'(expQ[k].size() > 0), 32'd1);
                    if (expQ[k].size() > 0)
                        checkOutput($sformatf("rsp_data_p%0d", k), 32'(bus.rsp_data), 32'(expQ[k].pop_front()));
                end
            end
        end
    end

    task automatic clearAll();
        bus.req_valid = '0;
        bus.req_wr    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic applyStimulus(input int k, input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bus.req_valid[k]           = 1'b1;
        bus.req_wr[k]              = wr;
        bus.req_addr[k*AW +: AW]   = addr;
        bus.req_wdata[k*DW +: DW]  = data;
    endtask

    // Called at a negedge: record what the coming edge will accept, then move to the next negedge.
    task automatic advanceCycle();
        logic [AW-1:0] a;
        for (int k = 0; k < P; k++) begin
            if (bus.req_valid[k] && bus.req_ready[k]) begin
                acc[k]++;
                a = bus.req_addr[k*AW +: AW];
                if (bus.req_wr[k]) goldMem[a] = bus.req_wdata[k*DW +: DW];
                else               expQ[k].push_back(goldMem[a]);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic waitDrain(input string tag);
        int budget = 200;
        while ((expQ[0].size() + expQ[1].size() + expQ[2].size()) != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput(tag, 32'(expQ[0].size() + expQ[1].size() + expQ[2].size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic doReset();
        clearAll();
        #2 reset_n = 1'b0;
        for (int k = 0; k < P; k++) expQ[k].delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s;
        int lone;
        for (int a = 0; a < (1 << AW); a++) goldMem[a] = initByte(AW'(a));
        for (int k = 0; k < P; k++) acc[k] = 0;
        clearAll();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_ram_wren", 32'(bus.ram_wren), 32'd0);
        checkOutput("rst_ram_address", 32'(bus.ram_address), 32'd0);
        checkOutput("rst_ram_data", 32'(bus.ram_data), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'h7);

        $display("[TB] single read on port 1");
        applyStimulus(1, 1'b0, 14'h0010, 8'h00);
        advanceCycle();
        clearAll();
        advanceCycle();
        checkOutput("rd_ram_address", 32'(bus.ram_address), 32'h0010);
        checkOutput("rd_ram_wren", 32'(bus.ram_wren), 32'd0);
        checkOutput("rd_rsp_edge1", 32'(bus.rsp_valid), 32'd0);
        advanceCycle();
        checkOutput("rd_rsp_edge2", 32'(bus.rsp_valid), 32'd0);
        advanceCycle();
        checkOutput("rd_rsp_edge3", 32'(bus.rsp_valid), 32'b010);
        checkOutput("rd_rsp_data", 32'(bus.rsp_data), 32'hA5);
        advanceCycle();
        checkOutput("rd_rsp_edge4", 32'(bus.rsp_valid), 32'd0);

        $display("[TB] write then read on port 0");
        applyStimulus(0, 1'b1, 14'h0100, 8'h3C);
        advanceCycle();
        applyStimulus(0, 1'b0, 14'h0100, 8'h00);
        advanceCycle();
        clearAll();
        checkOutput("wr_ram_wren_on", 32'(bus.ram_wren), 32'd1);
        checkOutput("wr_ram_address", 32'(bus.ram_address), 32'h0100);
        checkOutput("wr_ram_data", 32'(bus.ram_data), 32'h3C);
        advanceCycle();
        checkOutput("wr_ram_wren_off", 32'(bus.ram_wren), 32'd0);
        repeat (2) advanceCycle();
        checkOutput("wr_readback", 32'(bus.rsp_data), 32'h3C);
        waitDrain("wr_drain");

        $display("[TB] burst limit, ports 0 and 2");
        doReset();
        rspPort.delete();
        rspCycle.delete();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1'b0, 14'h1000 + 14'(i), 8'h00);
            applyStimulus(2, 1'b0, 14'h2000 + 14'(i), 8'h00);
            advanceCycle();
        end
        clearAll();
        waitDrain("burst_drain");
        checkOutput("burst_rsp_count", 32'(rspPort.size()), 32'd16);
        for (int i = 0; i < 16 && i < rspPort.size(); i++)
            checkOutput($sformatf("burst_order_%0d", i), 32'(rspPort[i]), (((i / 4) % 2) == 0) ? 32'd0 : 32'd2);
        if (rspCycle.size() == 16)
            checkOutput("burst_span", 32'(rspCycle[15] - rspCycle[0]), 32'd15);

        $display("[TB] lone port 2 streaming");
        rspPort.delete();
        rspCycle.delete();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(2, 1'b0, 14'h2100 + 14'(i), 8'h00);
            advanceCycle();
        end
        clearAll();
        waitDrain("lone_drain");
        lone = 0;
        foreach (rspPort[i]) if (rspPort[i] == 2) lone++;
        checkOutput("lone_rsp_count", 32'(lone), 32'd16);
        if (rspCycle.size() == 16)
            checkOutput("lone_span", 32'(rspCycle[15] - rspCycle[0]), 32'd15);

        $display("[TB] reset with reads in flight");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1'b0, 14'h1800 + 14'(i), 8'h00);
            advanceCycle();
        end
        clearAll();
        advanceCycle();
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rstmid_rsp_now", 32'(bus.rsp_valid), 32'd0);
        for (int k = 0; k < P; k++) expQ[k].delete();
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstmid_rsp_held", 32'(bus.rsp_valid), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput($sformatf("rstmid_rsp_after_%0d", i), 32'(bus.rsp_valid), 32'd0);
        end
        checkOutput("rstmid_req_ready", 32'(bus.req_ready), 32'h7);

        $display("[TB] full FIFO backpressure on port 0");
        for (int k = 0; k < P; k++) acc[k] = 0;
        s = 0;
        while (acc[0] < 9 && s < 40) begin
            clearAll();
            if (s <= 8) applyStimulus(1, 1'b0, 14'h1900 + 14'(s), 8'h00);
            if (s >= 1 && s <= 8) applyStimulus(2, 1'b0, 14'h2900 + 14'(s), 8'h00);
            if (s >= 1) applyStimulus(0, 1'b0, 14'h0900 + 14'(acc[0]), 8'h00);
            advanceCycle();
            if (s == 8) begin
                checkOutput("full_ready_low", 32'(bus.req_ready[0]), 32'd0);
                checkOutput("full_acc8", 32'(acc[0]), 32'd8);
            end
            if (s == 9) begin
                checkOutput("full_9th_held", 32'(acc[0]), 32'd8);
                checkOutput("full_ready_back", 32'(bus.req_ready[0]), 32'd1);
            end
            s++;
        end
        clearAll();
        checkOutput("full_total", 32'(acc[0]), 32'd9);
        checkOutput("full_steps", 32'(s), 32'd11);
        waitDrain("full_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
